pc_fetch_stage: RTL

- Instruction-fetch stage that owns the architectural PC register.
- Drives the current PC to the combinational next-PC logic and consumes its pc_next result.
- Issues instruction-memory requests with a ready handshake, buffers one returned instruction, and presents an IF/ID pipeline register to decode.
- Handles decode stall, flush/redirect, and syscall halt/resume.

---
 rtl/pc_fetch_stage_if.sv | 22 ++
 rtl/pc_fetch_stage.sv | 109 ++++++++++
 2 files changed

// File: rtl/pc_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory handshake plus the IF/ID register
// handed to decode (stall flows back from decode).
interface pc_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        stall;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr,
        input  imem_ready, imem_rdata, stall
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr,
        output imem_ready, imem_rdata, stall
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches with a ready handshake, buffers one
// word while decode stalls, and feeds the IF/ID register. Handles flush and halt/go.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    pc_fetch_stage_if.master bus,
    output logic [31:0]      o_pc,
    input  logic [31:0]      i_pc_next,
    input  logic             i_flush,
    input  logic             i_halt,
    input  logic             i_go,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_fetch_cnt
);
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [31:0]      r_pc;
    logic             r_if_valid;
    logic [31:0]      r_if_pc;
    logic [31:0]      r_if_instr;
    logic [31:0]      r_hold_pc;
    logic [31:0]      r_hold_instr;
    logic             r_halt_pend;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;

    // An empty IF/ID always accepts, regardless of stall.
    assign w_accept = bus.imem_ready && (!bus.stall || !r_if_valid);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_if_valid   <= 1'b0;
            r_if_pc      <= 32'h0;
            r_if_instr   <= 32'h0;
            r_hold_pc    <= 32'h0;
            r_hold_instr <= 32'h0;
            r_halt_pend  <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (i_flush) begin
                        r_if_valid  <= 1'b0;
                        r_pc        <= i_pc_next;
                        r_halt_pend <= 1'b0;
                    end else if (w_accept) begin
                        r_if_pc    <= r_pc;
                        r_if_instr <= bus.imem_rdata;
                        r_if_valid <= 1'b1;
                        r_pc       <= i_pc_next;
                        r_cnt      <= r_cnt + CNT_ONE;
                        if (i_halt) r_state <= S_HALT;
                    end else if (bus.imem_ready) begin
                        r_hold_pc    <= r_pc;
                        r_hold_instr <= bus.imem_rdata;
                        r_pc         <= i_pc_next;
                        r_halt_pend  <= i_halt;
                        r_state      <= S_HOLD;
                    end else begin
                        if (!bus.stall) r_if_valid <= 1'b0;
                        if (i_halt) r_state <= S_HALT;
                    end
                end
                S_HOLD: begin
                    if (i_flush) begin
                        r_if_valid  <= 1'b0;
                        r_pc        <= i_pc_next;
                        r_halt_pend <= 1'b0;
                        r_state     <= S_FETCH;
                    end else if (!bus.stall) begin
                        r_if_pc     <= r_hold_pc;
                        r_if_instr  <= r_hold_instr;
                        r_if_valid  <= 1'b1;
                        r_cnt       <= r_cnt + CNT_ONE;
                        r_halt_pend <= 1'b0;
                        r_state     <= (i_halt || r_halt_pend) ? S_HALT : S_FETCH;
                    end else if (i_halt) begin
                        r_halt_pend <= 1'b1;
                    end
                end
                S_HALT: begin
                    // Flush only redirects the PC here; halt wins over go.
                    if (i_flush) r_pc <= i_pc_next;
                    if (!bus.stall) r_if_valid <= 1'b0;
                    if (i_go && !i_halt) r_state <= S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign bus.imem_req  = !i_rst && (r_state == S_FETCH);
    assign bus.imem_addr = r_pc;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_pc     = r_if_pc;
    assign bus.if_instr  = r_if_instr;
    assign o_pc          = r_pc;
    assign o_halted      = (r_state == S_HALT);
    assign o_fetch_cnt   = r_cnt;
endmodule
